traffic_ctrl_param: RTL
=======================

Name: traffic_ctrl_param

Overview:
- Parametrised successor to the fixed-timing intersection controller: main street, side street, one pedestrian crossing.
- All phase durations are parameters, counted in seconds from an internal prescaler driven by the system clock. No separate clock or timer modules.
- Adds an optional all-red clearance interval and a night flashing mode.
- Sits at top level, driving the lamp outputs directly.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second (set small, e.g. 4, in simulation)
T_GREEN, 6, base green seconds (main and side)
T_EXT, 3, sensor extension seconds
T_YELLOW, 2, yellow seconds
T_WALK, 3, walk (all-red plus walk lamp) seconds
T_ALLRED, 1, all-red clearance seconds; 0 removes the clearance states
SEC_W, 4, width of the seconds counter; must hold the largest duration

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
sensor  in  1  side-street vehicle sensor, level
button_walk  in  1  pedestrian request, any pulse width of at least 1 cycle
flash_mode  in  1  night mode request, level
light_main  out  3  main lamps {red,yellow,green}, one-hot or 000
light_side  out  3  side lamps {red,yellow,green}, one-hot or 000
light_walk  out  1  walk lamp
walk_pending  out  1  latched, unserved walk request

Behaviour:
- Timing:
  - Prescaler counts 0..TICKS_PER_SEC-1 and emits a 1-cycle sec tick at terminal count.
  - Seconds counter increments on each tick.
  - Both counters clear on every state change.
  - Each timed state therefore lasts exactly D*TICKS_PER_SEC cycles. The transition occurs on the edge where the D-th tick fires.
- Outputs are registered and update on the same edge as the state register. There is no combinational path from inputs to outputs.
- States and lamps (main/side/walk):
  - MAIN_GRN 001/100/0, lasts T_GREEN.
  - MAIN_EXT 001/100/0, lasts T_EXT.
  - MAIN_YEL 010/100/0, lasts T_YELLOW.
  - CLR1 100/100/0, lasts T_ALLRED.
  - WALK 100/100/1, lasts T_WALK.
  - SIDE_GRN 100/001/0, lasts T_GREEN.
  - SIDE_EXT 100/001/0, lasts T_EXT.
  - SIDE_YEL 100/010/0, lasts T_YELLOW.
  - CLR2 100/100/0, lasts T_ALLRED.
  - FLASH: see below.
- Transitions at expiry:
  - MAIN_GRN -> MAIN_EXT if sensor=1 on the expiry cycle, else MAIN_YEL.
  - MAIN_EXT -> MAIN_YEL.
  - MAIN_YEL -> FLASH if flash_mode=1, else CLR1.
  - CLR1 -> WALK if walk_pending=1, else SIDE_GRN.
  - WALK -> SIDE_GRN.
  - SIDE_GRN -> SIDE_EXT if sensor=1, else SIDE_YEL.
  - SIDE_EXT -> SIDE_YEL.
  - SIDE_YEL -> FLASH if flash_mode=1, else CLR2.
  - CLR2 -> MAIN_GRN.
- T_ALLRED=0: CLR1 and CLR2 are bypassed. The CLR1 decision (WALK or SIDE_GRN) is taken directly at MAIN_YEL expiry; SIDE_YEL goes directly to MAIN_GRN.
- Walk latch:
  - Sets on any cycle with button_walk=1, except while in WALK.
  - Clears on the edge entering WALK. A press on that same edge is dropped.
  - Held through FLASH; only reset clears it otherwise.
- Flash mode:
  - Entered only at a yellow expiry; a green phase never ends early.
  - In FLASH: main alternates 010/000, side alternates 100/000, walk=0. Toggle occurs each sec tick; the first second after entry has lamps on.
  - flash_mode=0 is sampled at a sec tick in FLASH -> CLR2, or MAIN_GRN if T_ALLRED=0.
- Reset (reset=0 at a rising edge), including mid-phase:
  - state=MAIN_GRN, both counters 0, walk_pending=0.
  - light_main=001, light_side=100, light_walk=0.
  - Outputs hold these values while reset stays low.
- Safety invariant: main and side are never simultaneously non-red, except in FLASH where main is yellow/off. light_walk=1 only with both reds on.

Test Plan:
- TICKS_PER_SEC=4, defaults, sensor=0, no walk, release reset -> main green 24 cyc, yellow 8, all-red 4, side green 24, yellow 8, all-red 4; period 72 cycles, repeating.
- sensor=1 held across MAIN_GRN expiry -> main green 36 cycles total, then 8 yellow; likewise side green 36 when held at SIDE_GRN expiry.
- 1-cycle button_walk at cycle 5 of MAIN_GRN -> walk_pending=1 next edge; after CLR1, light_walk=1 with 100/100 for 12 cycles; walk_pending=0 from WALK entry; then side green.
- flash_mode=1 asserted mid SIDE_GRN -> side green and yellow complete, then main 010/000 and side 100/000 toggling every 4 cycles; deassert -> leaves at next tick to CLR2 (4 cycles) then MAIN_GRN.
- reset=0 for 1 cycle during WALK with walk re-pressed -> next edge 001/100/0, walk_pending=0, full 24-cycle green follows.
- Build with T_ALLRED=0 -> MAIN_YEL goes straight to SIDE_GRN; SIDE_YEL goes straight to MAIN_GRN; period 64 cycles.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param
//   Intersection controller for a main street, a side street and one
//   pedestrian crossing. Phase durations are given in seconds; a prescaler
//   derived from clk produces a one-cycle second tick.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   sensor       side-street vehicle sensor (level)
//   button_walk  pedestrian request (pulse of one cycle or more)
//   flash_mode   night flashing request (level)
//   light_main   main lamps {red,yellow,green}
//   light_side   side lamps {red,yellow,green}
//   light_walk   walk lamp
//   walk_pending latched, not yet served pedestrian request
//   state_dbg    current FSM state encoding (debug visibility)
module traffic_ctrl_param #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int T_GREEN       = 6,
  parameter int T_EXT         = 3,
  parameter int T_YELLOW      = 2,
  parameter int T_WALK        = 3,
  parameter int T_ALLRED      = 1,
  parameter int SEC_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       button_walk,
  input  logic       flash_mode,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       light_walk,
  output logic       walk_pending,
  output logic [3:0] state_dbg
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  // Last seconds-counter value of each timed phase.
  localparam logic [SEC_W-1:0] S_GREEN  = SEC_W'(T_GREEN - 1);
  localparam logic [SEC_W-1:0] S_EXT    = SEC_W'(T_EXT - 1);
  localparam logic [SEC_W-1:0] S_YELLOW = SEC_W'(T_YELLOW - 1);
  localparam logic [SEC_W-1:0] S_WALK   = SEC_W'(T_WALK - 1);
  localparam logic [SEC_W-1:0] S_ALLRED = SEC_W'((T_ALLRED > 0) ? T_ALLRED - 1 : 0);
  localparam bit HAS_CLR = (T_ALLRED > 0);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [3:0] {
    MAIN_GRN = 4'd0,
    MAIN_EXT = 4'd1,
    MAIN_YEL = 4'd2,
    CLR1     = 4'd3,
    WALK     = 4'd4,
    SIDE_GRN = 4'd5,
    SIDE_EXT = 4'd6,
    SIDE_YEL = 4'd7,
    CLR2     = 4'd8,
    FLASH    = 4'd9
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] sec_last;
  logic             tick, expire;
  logic             flash_on, flash_on_d;
  logic             walk_d;
  logic [2:0]       main_d, side_d;
  logic             lamp_walk_d;

  assign tick      = (presc == PRESC_LAST);
  assign state_dbg = state;

  always_comb begin
    sec_last = S_GREEN;
    case (state)
      MAIN_GRN, SIDE_GRN: sec_last = S_GREEN;
      MAIN_EXT, SIDE_EXT: sec_last = S_EXT;
      MAIN_YEL, SIDE_YEL: sec_last = S_YELLOW;
      CLR1, CLR2:         sec_last = S_ALLRED;
      WALK:               sec_last = S_WALK;
      default:            sec_last = '0;
    endcase
  end

  // A phase ends on the edge where its D-th second tick fires.
  assign expire = tick && (sec == sec_last);

  always_comb begin
    state_d = state;
    case (state)
      MAIN_GRN: if (expire) state_d = sensor ? MAIN_EXT : MAIN_YEL;
      MAIN_EXT: if (expire) state_d = MAIN_YEL;
      MAIN_YEL: if (expire) begin
        if (flash_mode)   state_d = FLASH;
        else if (HAS_CLR) state_d = CLR1;
        else              state_d = walk_pending ? WALK : SIDE_GRN;
      end
      CLR1:     if (expire) state_d = walk_pending ? WALK : SIDE_GRN;
      WALK:     if (expire) state_d = SIDE_GRN;
      SIDE_GRN: if (expire) state_d = sensor ? SIDE_EXT : SIDE_YEL;
      SIDE_EXT: if (expire) state_d = SIDE_YEL;
      SIDE_YEL: if (expire) begin
        if (flash_mode)   state_d = FLASH;
        else if (HAS_CLR) state_d = CLR2;
        else              state_d = MAIN_GRN;
      end
      CLR2:     if (expire) state_d = MAIN_GRN;
      FLASH:    if (tick && !flash_mode) state_d = HAS_CLR ? CLR2 : MAIN_GRN;
      default:  state_d = MAIN_GRN;
    endcase
  end

  // Flash phase starts lit and toggles on every second tick it stays.
  always_comb begin
    flash_on_d = flash_on;
    if (state_d == FLASH && state != FLASH) flash_on_d = 1'b1;
    else if (state == FLASH && tick)        flash_on_d = ~flash_on;
  end

  // Entering WALK clears the request and wins over a press on that edge.
  always_comb begin
    walk_d = walk_pending;
    if (state_d == WALK && state != WALK)  walk_d = 1'b0;
    else if (button_walk && state != WALK) walk_d = 1'b1;
  end

  // Lamps are decoded from the next state so the registered outputs
  // change on the same edge as the state register.
  always_comb begin
    main_d      = LAMP_RED;
    side_d      = LAMP_RED;
    lamp_walk_d = 1'b0;
    case (state_d)
      MAIN_GRN, MAIN_EXT: main_d = LAMP_GRN;
      MAIN_YEL:           main_d = LAMP_YEL;
      WALK:               lamp_walk_d = 1'b1;
      SIDE_GRN, SIDE_EXT: side_d = LAMP_GRN;
      SIDE_YEL:           side_d = LAMP_YEL;
      FLASH: begin
        main_d = flash_on_d ? LAMP_YEL : LAMP_OFF;
        side_d = flash_on_d ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= MAIN_GRN;
      presc        <= '0;
      sec          <= '0;
      flash_on     <= 1'b0;
      walk_pending <= 1'b0;
      light_main   <= LAMP_GRN;
      light_side   <= LAMP_RED;
      light_walk   <= 1'b0;
    end else begin
      state        <= state_d;
      flash_on     <= flash_on_d;
      walk_pending <= walk_d;
      light_main   <= main_d;
      light_side   <= side_d;
      light_walk   <= lamp_walk_d;
      if (state_d != state) begin
        presc <= '0;
        sec   <= '0;
      end else if (tick) begin
        presc <= '0;
        sec   <= sec + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule
